scalar_add_pipe: RTL

Parametrised, fully pipelined integer add/subtract functional unit: the next generation of the fixed 64-bit scalar adder, also used for the 24-bit address adder. It takes one operation per clock with a valid qualifier, carries the destination register tag through the pipeline, and returns result, tag and valid after a configurable fixed latency. Per-register pending flags let issue logic detect reservation hazards. Subtraction is two's complement; the carry out of the MSB is discarded.

---
 rtl/scalar_add_pipe.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/scalar_add_pipe.sv
// rtl/scalar_add_pipe.sv - pipelined add/subtract unit with dest tag and pending flags; SCALAR_ADD_OVF_EN adds o_ovf
module scalar_add_pipe #(
    parameter int         WIDTH   = 64,
    parameter int         LATENCY = 3,
    parameter int         NREG    = 8,
    parameter logic [6:0] ADD_OP  = 7'b0110000,
    parameter logic [6:0] SUB_OP  = 7'b0110001,
    localparam int        DW      = (NREG > 1) ? $clog2(NREG) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [6:0]       i_instr,
    input  logic [DW-1:0]    i_dest,
    input  logic [WIDTH-1:0] i_sj,
    input  logic [WIDTH-1:0] i_sk,
    output logic             o_valid,
    output logic [DW-1:0]    o_dest,
    output logic [WIDTH-1:0] o_result,
    output logic [NREG-1:0]  o_pending
`ifdef SCALAR_ADD_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int CW = $clog2(LATENCY + 1);

    logic             w_is_add;
    logic             w_is_sub;
    logic             w_accept;
    logic [WIDTH-1:0] w_opb;
    logic [WIDTH-1:0] w_sum;

    logic [LATENCY-1:0]            r_vld;
    logic [LATENCY-1:0][DW-1:0]    r_dest;
    logic [LATENCY-1:0][WIDTH-1:0] r_res;

    logic [NREG-1:0][CW-1:0] r_cnt;
    logic [NREG-1:0][CW-1:0] w_cnt_nxt;
    logic [NREG-1:0]         w_pend_nxt;
    logic [NREG-1:0]         w_inc;
    logic [NREG-1:0]         w_dec;
    logic [NREG-1:0]         r_pending;

    assign w_is_add = (i_instr == ADD_OP);
    assign w_is_sub = (i_instr == SUB_OP);
    assign w_accept = i_valid && (w_is_add || w_is_sub);

    // Subtract is Sj + ~Sk + 1; the carry out of the MSB falls off the top.
    assign w_opb = w_is_sub ? ~i_sk : i_sk;
    assign w_sum = i_sj + w_opb + WIDTH'(w_is_sub);

`ifdef SCALAR_ADD_OVF_EN
    logic               w_ovf;
    logic [LATENCY-1:0] r_ovf;

    // Overflow: operands (after inverting Sk for subtract) share a sign that the result lost.
    assign w_ovf = (i_sj[WIDTH-1] == w_opb[WIDTH-1]) && (w_sum[WIDTH-1] != i_sj[WIDTH-1]);

    // Overflow flag rides alongside the result; holds with it while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= '0;
        end else begin
            if (w_accept) begin
                r_ovf[0] <= w_ovf;
            end
            for (int k = 1; k < LATENCY; k++) begin
                if (r_vld[k-1]) begin
                    r_ovf[k] <= r_ovf[k-1];
                end
            end
        end
    end

    assign o_ovf = r_ovf[LATENCY-1];
`endif

    // Result pipeline: stage 0 captures the sum, each later stage copies only
    // valid entries so the final stage holds its last value while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld  <= '0;
            r_dest <= '0;
            r_res  <= '0;
        end else begin
            r_vld[0] <= w_accept;
            if (w_accept) begin
                r_dest[0] <= i_dest;
                r_res[0]  <= w_sum;
            end
            for (int k = 1; k < LATENCY; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_dest[k] <= r_dest[k-1];
                    r_res[k]  <= r_res[k-1];
                end
            end
        end
    end

    assign o_valid  = r_vld[LATENCY-1];
    assign o_dest   = r_dest[LATENCY-1];
    assign o_result = r_res[LATENCY-1];

    // Per-register issue and retire events this cycle.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int d = 0; d < NREG; d++) begin
            w_inc[d] = w_accept && (i_dest == DW'(d));
            w_dec[d] = o_valid && (o_dest == DW'(d));
        end
    end

    // Next in-flight count; a simultaneous issue and retire cancel out.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_pend_nxt = '0;
        for (int d = 0; d < NREG; d++) begin
            if (w_inc[d] && !w_dec[d]) begin
                w_cnt_nxt[d] = r_cnt[d] + CW'(1);
            end else if (w_dec[d] && !w_inc[d]) begin
                w_cnt_nxt[d] = r_cnt[d] - CW'(1);
            end
            w_pend_nxt[d] = (w_cnt_nxt[d] != '0);
        end
    end

    // Counters and registered pending flags, derived from the next count so
    // the flag rises the cycle after issue and falls after the output cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_pending <= '0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_pending <= w_pend_nxt;
        end
    end

    assign o_pending = r_pending;

endmodule
